// File: rtl/sram_sync_pkg.sv
// Shared request-type encodings and the response payload layout for the
// synchronous valid/ready SRAM.
package sram_sync_pkg;

  localparam int unsigned SRAM_DATA_NBITS   = 32;
  localparam int unsigned SRAM_OPAQUE_NBITS = 8;

  localparam logic SRAM_REQ_READ  = 1'b0;
  localparam logic SRAM_REQ_WRITE = 1'b1;

  // Response payload at the default widths.
  typedef struct packed {
    logic                         rtype;
    logic [SRAM_OPAQUE_NBITS-1:0] opaque;
    logic [SRAM_DATA_NBITS-1:0]   data;
  } sram_resp_t;

endpackage

// File: rtl/sram_sync_resp_queue.sv
// Small circular FIFO that holds responses while the consumer applies
// backpressure.
module sram_sync_resp_queue
  import sram_sync_pkg::*;
#(
  parameter int unsigned p_width     = 41,
  parameter int unsigned p_depth     = 2,
  localparam int unsigned c_cnt_nbits = $clog2(p_depth + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enq_val,
  input  logic [p_width-1:0]     i_enq_data,
  output logic                   o_deq_val,
  input  logic                   i_deq_rdy,
  output logic [p_width-1:0]     o_deq_data_c,
  output logic [c_cnt_nbits-1:0] o_count,
  output logic                   o_empty
);

  localparam int unsigned c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1;

  logic [p_width-1:0]     r_buf [p_depth];
  logic [c_ptr_nbits-1:0] r_wr_ptr;
  logic [c_ptr_nbits-1:0] r_rd_ptr;
  logic [c_cnt_nbits-1:0] r_count;
  logic                   r_empty;
  logic                   r_deq_val;

  logic                   w_push;
  logic                   w_pop;
  logic [c_cnt_nbits-1:0] w_cnt_next;

  function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
    return (p == c_ptr_nbits'(p_depth - 1)) ? '0 : p + c_ptr_nbits'(1);
  endfunction

  assign w_push = i_enq_val;
  assign w_pop  = r_deq_val & i_deq_rdy;

  always_comb begin
    w_cnt_next = r_count;
    if (w_push && !w_pop)
      w_cnt_next = r_count + c_cnt_nbits'(1);
    else if (!w_push && w_pop)
      w_cnt_next = r_count - c_cnt_nbits'(1);
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push)
      r_buf[r_wr_ptr] <= i_enq_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_deq_val <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count   <= w_cnt_next;
      r_empty   <= (w_cnt_next == '0);
      r_deq_val <= (w_cnt_next != '0);
    end
  end

  assign o_deq_val    = r_deq_val;
  assign o_deq_data_c = r_buf[r_rd_ptr];
  assign o_count      = r_count;
  assign o_empty      = r_empty;

endmodule

// File: rtl/sram_sync_vr.sv
// Single-port synchronous SRAM with valid/ready request/response ports,
// registered read data, byte-masked writes and a backpressure queue.
module sram_sync_vr
  import sram_sync_pkg::*;
#(
  parameter int unsigned p_data_nbits   = 32,
  parameter int unsigned p_num_entries  = 256,
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_resp_depth   = 2,
  localparam int unsigned c_addr_nbits  = $clog2(p_num_entries),
  localparam int unsigned c_data_nbytes = p_data_nbits / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req_val,
  output logic                      o_req_rdy_c,
  input  logic                      i_req_type,
  input  logic [p_opaque_nbits-1:0] i_req_opaque,
  input  logic [c_addr_nbits-1:0]   i_req_idx,
  input  logic [c_data_nbytes-1:0]  i_req_wben,
  input  logic [p_data_nbits-1:0]   i_req_wdata,
  output logic                      o_resp_val_c,
  input  logic                      i_resp_rdy,
  output logic                      o_resp_type_c,
  output logic [p_opaque_nbits-1:0] o_resp_opaque_c,
  output logic [p_data_nbits-1:0]   o_resp_rdata_c
);

  localparam int unsigned c_entry_nbits = 1 + p_opaque_nbits + p_data_nbits;
  localparam int unsigned c_cnt_nbits   = $clog2(p_resp_depth + 1);
  localparam int unsigned c_occ_nbits   = c_cnt_nbits + 1;

  typedef struct packed {
    logic                      rtype;
    logic [p_opaque_nbits-1:0] opaque;
    logic [p_data_nbits-1:0]   data;
  } entry_t;

  logic [p_data_nbits-1:0] r_mem [p_num_entries];
  entry_t                  r_s1;
  logic                    r_s1_val;

  logic                    w_req_fire;
  logic                    w_is_write;
  logic                    w_q_enq;
  logic                    w_q_deq_val;
  logic                    w_q_empty;
  logic [c_cnt_nbits-1:0]  w_q_count;
  entry_t                  w_q_head;
  entry_t                  w_resp;
  logic [c_occ_nbits-1:0]  w_occ;

  assign w_req_fire = i_req_val & o_req_rdy_c;
  assign w_is_write = (i_req_type == SRAM_REQ_WRITE);

  // Behavioural array; kept in its own block so a macro can replace it.
  always_ff @(posedge clk) begin
    if (w_req_fire && w_is_write) begin
      for (int i = 0; i < int'(c_data_nbytes); i++) begin
        if (i_req_wben[i])
          r_mem[i_req_idx][8*i +: 8] <= i_req_wdata[8*i +: 8];
      end
    end
  end

  // Stage 1 always drains each cycle (bypassed or enqueued), so its valid
  // simply tracks whether a request fired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_val <= 1'b0;
      r_s1     <= '0;
    end else begin
      r_s1_val <= w_req_fire;
      if (w_req_fire) begin
        r_s1.rtype  <= i_req_type;
        r_s1.opaque <= i_req_opaque;
        r_s1.data   <= w_is_write ? '0 : r_mem[i_req_idx];
      end
    end
  end

  assign w_q_enq = r_s1_val & ~(w_q_empty & i_resp_rdy);

  sram_sync_resp_queue #(
    .p_width (c_entry_nbits),
    .p_depth (p_resp_depth)
  ) u_resp_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enq_val    (w_q_enq),
    .i_enq_data   (r_s1),
    .o_deq_val    (w_q_deq_val),
    .i_deq_rdy    (i_resp_rdy),
    .o_deq_data_c (w_q_head),
    .o_count      (w_q_count),
    .o_empty      (w_q_empty)
  );

  assign w_resp          = w_q_empty ? r_s1 : w_q_head;
  assign o_resp_val_c    = r_s1_val | w_q_deq_val;
  assign o_resp_type_c   = w_resp.rtype;
  assign o_resp_opaque_c = w_resp.opaque;
  assign o_resp_rdata_c  = w_resp.data;

  // Occupancy is state-only, so req_rdy has no path from resp_rdy.
  assign w_occ       = c_occ_nbits'(w_q_count) + c_occ_nbits'(r_s1_val);
  assign o_req_rdy_c = (w_occ < c_occ_nbits'(p_resp_depth));

endmodule

// File: tb/tb_sram_sync_vr.sv
// Directed and randomised bench for sram_sync_vr with an in-order
// response scoreboard and a reference memory model.
module tb_sram_sync_vr;
  import sram_sync_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_val;
  logic        req_rdy;
  logic        req_type;
  logic [7:0]  req_opaque;
  logic [7:0]  req_idx;
  logic [3:0]  req_wben;
  logic [31:0] req_wdata;
  logic        resp_val;
  logic        resp_rdy;
  logic        resp_type;
  logic [7:0]  resp_opaque;
  logic [31:0] resp_rdata;

  int          checks   = 0;
  int          failures = 0;
  sram_resp_t  sb [$];
  logic [31:0] model [256];

  always #5 clk = ~clk;

  sram_sync_vr #(
    .p_data_nbits   (32),
    .p_num_entries  (256),
    .p_opaque_nbits (8),
    .p_resp_depth   (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req_val       (req_val),
    .o_req_rdy_c     (req_rdy),
    .i_req_type      (req_type),
    .i_req_opaque    (req_opaque),
    .i_req_idx       (req_idx),
    .i_req_wben      (req_wben),
    .i_req_wdata     (req_wdata),
    .o_resp_val_c    (resp_val),
    .i_resp_rdy      (resp_rdy),
    .o_resp_type_c   (resp_type),
    .o_resp_opaque_c (resp_opaque),
    .o_resp_rdata_c  (resp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, then account for whatever fires at the next posedge.
  task automatic step(input logic rv, input logic rt, input logic [7:0] op,
                      input logic [7:0] idx, input logic [3:0] wben,
                      input logic [31:0] wd, input logic rr, output bit fired);
    sram_resp_t e;
    @(negedge clk);
    req_val = rv; req_type = rt; req_opaque = op; req_idx = idx;
    req_wben = wben; req_wdata = wd; resp_rdy = rr;
    #1;
    fired = rv && req_rdy;
    if (resp_val && rr) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 64'(resp_val), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("resp_type", 64'(resp_type), 64'(e.rtype));
        chk("resp_opaque", 64'(resp_opaque), 64'(e.opaque));
        chk("resp_rdata", 64'(resp_rdata), 64'(e.data));
      end
    end
    if (fired) begin
      e.rtype  = rt;
      e.opaque = op;
      if (rt == SRAM_REQ_WRITE) begin
        for (int b = 0; b < 4; b++)
          if (wben[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        e.data = '0;
      end else begin
        e.data = model[idx];
      end
      sb.push_back(e);
    end
  endtask

  task automatic idle(input logic rr);
    bit f;
    step(1'b0, 1'b0, 8'h0, 8'h0, 4'h0, 32'h0, rr, f);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) idle(1'b1);
    chk("drain_empty", 64'(sb.size()), 64'(0));
    idle(1'b1);
    chk("no_extra_resp", 64'(resp_val), 64'(0));
  endtask

  initial begin
    bit f;
    int issued;
    rst_n = 1'b0; req_val = 1'b0; req_type = 1'b0; req_opaque = '0;
    req_idx = '0; req_wben = '0; req_wdata = '0; resp_rdy = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 'x;

    repeat (2) @(negedge clk);
    chk("in_reset_resp_val", 64'(resp_val), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'(1));
    chk("rst_resp_val", 64'(resp_val), 64'(0));
    chk("rst_resp_type", 64'(resp_type), 64'(0));
    chk("rst_resp_opaque", 64'(resp_opaque), 64'(0));
    chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));

    // Write then read idx 3, each response one cycle after its request.
    step(1'b1, SRAM_REQ_WRITE, 8'h01, 8'd3, 4'hF, 32'hDEADBEEF, 1'b1, f);
    chk("wr3_accept", 64'(f), 64'(1));
    step(1'b1, SRAM_REQ_READ, 8'h05, 8'd3, 4'h0, 32'h0, 1'b1, f);
    chk("wr3_resp_latency", 64'(resp_val), 64'(1));
    idle(1'b1);
    chk("rd3_resp_latency", 64'(resp_val), 64'(1));
    chk("rd3_rdata_direct", 64'(resp_rdata), 64'(32'hDEADBEEF));
    chk("rd3_opaque_direct", 64'(resp_opaque), 64'(8'h05));
    drain(10);

    // Byte-masked write merge.
    step(1'b1, SRAM_REQ_WRITE, 8'h06, 8'd7, 4'hF, 32'hAABBCCDD, 1'b1, f);
    step(1'b1, SRAM_REQ_WRITE, 8'h07, 8'd7, 4'h5, 32'h11223344, 1'b1, f);
    step(1'b1, SRAM_REQ_READ,  8'h08, 8'd7, 4'h0, 32'h0, 1'b1, f);
    idle(1'b1);
    chk("rd7_merge_direct", 64'(resp_rdata), 64'(32'hAA22CC44));
    drain(10);

    // Streaming at full rate.
    for (int i = 0; i < 16; i++)
      step(1'b1, SRAM_REQ_WRITE, 8'(i), 8'(16 + i), 4'hF, 32'h10000000 + 32'(i) * 32'h01010101, 1'b1, f);
    drain(10);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, SRAM_REQ_READ, 8'(8'h80 + i), 8'(16 + i), 4'h0, 32'h0, 1'b1, f);
      chk("stream_accept", 64'(f), 64'(1));
      if (i > 0) chk("stream_resp_val", 64'(resp_val), 64'(1));
    end
    drain(10);

    // Backpressure: only two requests may be outstanding.
    issued = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, SRAM_REQ_READ, 8'(8'h40 + issued), 8'(16 + issued), 4'h0, 32'h0, 1'b0, f);
      chk("bp_accept", 64'(f), 64'(c < 2));
      if (f) issued++;
    end
    chk("bp_outstanding", 64'(sb.size()), 64'(2));
    for (int k = 0; k < 12 && issued < 4; k++) begin
      step(1'b1, SRAM_REQ_READ, 8'(8'h40 + issued), 8'(16 + issued), 4'h0, 32'h0, 1'b1, f);
      if (k < 2) chk("bp_release_accept", 64'(f), 64'(k >= 1));
      if (f) issued++;
    end
    chk("bp_all_issued", 64'(issued), 64'(4));
    drain(10);

    // Asynchronous reset with two responses queued.
    step(1'b1, SRAM_REQ_READ, 8'h21, 8'd3, 4'h0, 32'h0, 1'b0, f);
    step(1'b1, SRAM_REQ_READ, 8'h22, 8'd7, 4'h0, 32'h0, 1'b0, f);
    idle(1'b0);
    chk("pre_reset_resp_val", 64'(resp_val), 64'(1));
    chk("pre_reset_req_rdy", 64'(req_rdy), 64'(0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_resp_val", 64'(resp_val), 64'(0));
    chk("mid_reset_req_rdy", 64'(req_rdy), 64'(1));
    chk("mid_reset_opaque", 64'(resp_opaque), 64'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, SRAM_REQ_READ, 8'h31, 8'd7, 4'h0, 32'h0, 1'b1, f);
    step(1'b1, SRAM_REQ_READ, 8'h32, 8'd3, 4'h0, 32'h0, 1'b1, f);
    idle(1'b1);
    chk("retained_rd3_direct", 64'(resp_rdata), 64'(32'hDEADBEEF));
    drain(10);

    // Randomised valid/ready on both sides over a prefilled window.
    for (int i = 0; i < 16; i++)
      step(1'b1, SRAM_REQ_WRITE, 8'h0, 8'(32 + i), 4'hF, $urandom, 1'b1, f);
    drain(10);
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           8'(32 + $urandom_range(0, 15)), 4'($urandom), $urandom,
           1'($urandom_range(0, 9) < 7), f);
    end
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
